// File: rtl/ps2_key_event.sv
// ps2_key_event
//   Turns the PS/2 scan-byte stream into complete key events {ext, brk, code}.
//   It resolves the E0/F0 prefixes, drops error bytes (00, FF, E1), and
//   abandons a pending prefix after TIMEOUT_CYC idle cycles. Decoded events
//   are buffered in a first-word-fall-through FIFO with a valid/ready handshake.
//
//   Optional feature macro: PS2_TYPEMATIC_FILTER_EN
//     When defined, a make event that repeats the currently held key is dropped.
//     A break event is always emitted.
//
// Parameters
//   FIFO_DEPTH   event FIFO entries (power of two, >= 2)
//   TIMEOUT_CYC  idle cycles after which a pending prefix is abandoned
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   scan_done_tick  one-cycle strobe, scan_out valid
//   scan_out        received scan byte
//   ev_valid        FIFO non-empty, head event presented
//   ev_ready        consumer accepts the head event
//   ev_code         head event key code
//   ev_break        head event is a release
//   ev_ext          head event is extended
//   ev_count        FIFO occupancy, 0..FIFO_DEPTH
//   overflow        sticky: an event was lost to a full FIFO
//
// Prefix FSM
//   state   | meaning
//   IDLE    | no prefix pending
//   EXT     | E0 seen
//   BRK     | F0 seen
//   EXT_BRK | both E0 and F0 seen
module ps2_key_event #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          scan_done_tick,
    input  logic [7:0]                    scan_out,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_break,
    output logic                          ev_ext,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tmo_cnt;
    logic          w_tmo_hit;
    logic          w_err_byte;
    logic          w_emit_raw;
    logic          w_emit;
    logic [9:0]    w_ev_data;

    assign w_err_byte = (scan_out == 8'h00) || (scan_out == 8'hFF) || (scan_out == 8'hE1);

    // A strobe in the firing cycle wins over the timeout.
    assign w_tmo_hit = (r_state != IDLE) && (r_tmo_cnt == TMO_LAST) && !scan_done_tick;

    assign w_ev_data = {(r_state == EXT) || (r_state == EXT_BRK),
                        (r_state == BRK) || (r_state == EXT_BRK),
                        scan_out};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit_raw  = 1'b0;
        if (scan_done_tick) begin
            if (scan_out == 8'hE0) begin
                case (r_state)
                    IDLE:    w_state_nxt = EXT;
                    BRK:     w_state_nxt = EXT_BRK;
                    default: w_state_nxt = r_state;
                endcase
            end else if (scan_out == 8'hF0) begin
                case (r_state)
                    IDLE:    w_state_nxt = BRK;
                    EXT:     w_state_nxt = EXT_BRK;
                    default: w_state_nxt = r_state;
                endcase
            end else if (w_err_byte) begin
                w_state_nxt = IDLE;
            end else begin
                w_emit_raw  = 1'b1;
                w_state_nxt = IDLE;
            end
        end else if (w_tmo_hit) begin
            w_state_nxt = IDLE;
        end
    end

    // Counts idle cycles since the last strobe while a prefix is pending.
    // TW holds TIMEOUT_CYC, so the increment cannot wrap before the hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if (scan_done_tick || (r_state == IDLE)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       r_held;
    logic [8:0] r_held_key;
    logic       w_key_match;

    assign w_key_match = r_held && (r_held_key == {w_ev_data[9], w_ev_data[7:0]});
    assign w_emit      = w_emit_raw && !(w_key_match && !w_ev_data[8]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_held     <= 1'b0;
            r_held_key <= '0;
        end else if (w_emit_raw) begin
            if (!w_ev_data[8]) begin
                r_held     <= 1'b1;
                r_held_key <= {w_ev_data[9], w_ev_data[7:0]};
            end else if (w_key_match) begin
                r_held <= 1'b0;
            end
        end
    end
`else
    assign w_emit = w_emit_raw;
`endif

    // Event FIFO. Pointers carry one extra bit so full and empty are distinct.
    logic [9:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_overflow;
    logic        w_full;
    logic        w_pop;
    logic        w_push;

    assign ev_count = r_wptr - r_rptr;
    assign ev_valid = (ev_count != '0);
    assign w_full   = (ev_count == DEPTH);
    assign w_pop    = ev_valid && ev_ready;
    // When full, a simultaneous pop frees the slot being written.
    assign w_push   = w_emit && (!w_full || w_pop);
    assign overflow = r_overflow;

    assign {ev_ext, ev_break, ev_code} = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= w_ev_data;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_emit && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_event.sv
module tb_ps2_key_event;

    localparam int D = 4;
    localparam int T = 20;

`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam int EXP_TM = 3;
`else
    localparam int EXP_TM = 5;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scan_done_tick = 1'b0;
    logic [7:0] scan_out = 8'h00;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic [2:0] ev_count;
    logic       overflow;

    ps2_key_event #(.FIFO_DEPTH(D), .TIMEOUT_CYC(T)) dut (
        .clk            (clk),
        .reset          (reset),
        .scan_done_tick (scan_done_tick),
        .scan_out       (scan_out),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_code        (ev_code),
        .ev_break       (ev_break),
        .ev_ext         (ev_ext),
        .ev_count       (ev_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_pops   = 0;

    // Reference model: prefix flags, time of last strobe, FIFO occupancy,
    // sticky overflow, held key, and the queue of expected events.
    bit         m_ext = 0;
    bit         m_brk = 0;
    int         m_last = 0;
    int         cyc = 0;
    int         m_count = 0;
    bit         m_ovf = 0;
    bit         m_held = 0;
    logic [8:0] m_hkey = '0;
    logic [9:0] sb[$];
    bit         mon_en = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        sb.delete();
        m_count = 0;
        m_ovf   = 0;
        m_ext   = 0;
        m_brk   = 0;
        m_held  = 0;
    endfunction

    // One clock cycle of stimulus; the model's visible state is committed
    // after the edge so the monitor always compares against current state.
    task automatic step(input bit strb, input logic [7:0] b, input bit rdy);
        bit         ev;
        logic [9:0] evd;
        bit         pop;
        bit         push;
        ev  = 0;
        evd = '0;
        scan_done_tick = strb;
        scan_out       = b;
        ev_ready       = rdy;
        if (strb) begin
            if ((m_ext || m_brk) && (cyc - m_last) > T) begin
                m_ext = 0;
                m_brk = 0;
            end
            m_last = cyc;
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (b == 8'h00 || b == 8'hFF || b == 8'hE1) begin
                m_ext = 0;
                m_brk = 0;
            end else begin
                ev    = 1;
                evd   = {m_ext, m_brk, b};
                m_ext = 0;
                m_brk = 0;
            end
        end
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (ev) begin
            if (!evd[8]) begin
                if (m_held && m_hkey == {evd[9], evd[7:0]}) ev = 0;
                else begin
                    m_held = 1;
                    m_hkey = {evd[9], evd[7:0]};
                end
            end else if (m_held && m_hkey == {evd[9], evd[7:0]}) begin
                m_held = 0;
            end
        end
`endif
        pop  = (m_count > 0) && rdy;
        push = ev && ((m_count < D) || pop);
        @(posedge clk);
        #1;
        cyc++;
        m_count = m_count + int'(push) - int'(pop);
        if (ev && !push) m_ovf = 1;
        if (push) sb.push_back(evd);
        scan_done_tick = 1'b0;
    endtask

    // Monitor: status every cycle, head event on every handshake.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            check("ev_valid", 32'(ev_valid), 32'(m_count != 0));
            check("ev_count", 32'(ev_count), 32'(m_count));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (ev_valid && ev_ready) begin
                n_pops++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_event actual=%0h expected=none",
                             {ev_ext, ev_break, ev_code});
                end else begin
                    logic [9:0] exp_ev;
                    exp_ev = sb.pop_front();
                    check("head_event", 32'({ev_ext, ev_break, ev_code}), 32'(exp_ev));
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 40 && m_count > 0; i++) step(0, 8'h00, 1);
    endtask

    logic [7:0] tbl [12];
    int         p0;

    initial begin
        tbl = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h00, 8'hFF, 8'hE1,
                8'h1C, 8'h15, 8'h75, 8'h1C, 8'h5A};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_count", 32'(ev_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_head", 32'({ev_ext, ev_break, ev_code}), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1;

        // Single make with the consumer ready.
        step(1, 8'h1C, 1);
        check("t1_valid", 32'(ev_valid), 1);
        check("t1_head", 32'({ev_ext, ev_break, ev_code}), 32'h01C);
        step(0, 8'h00, 1);
        check("t1_count_after_pop", 32'(ev_count), 0);

        // Break, then extended break, consumer stalled.
        step(1, 8'hF0, 0);
        step(1, 8'h1C, 0);
        step(1, 8'hE0, 0);
        step(1, 8'hF0, 0);
        step(1, 8'h75, 0);
        check("t2_count", 32'(ev_count), 2);
        check("t2_head0", 32'({ev_ext, ev_break, ev_code}), 32'h11C);
        step(0, 8'h00, 1);
        check("t2_head1", 32'({ev_ext, ev_break, ev_code}), 32'h375);
        drain();

        // Timeout: a gap of T idle cycles abandons E0.
        step(1, 8'hE0, 0);
        repeat (T) step(0, 8'h00, 0);
        step(1, 8'h1C, 0);
        check("t3_timeout_head", 32'({ev_ext, ev_break, ev_code}), 32'h01C);
        drain();
        // A strobe in the firing cycle keeps the prefix.
        step(1, 8'hE0, 0);
        repeat (T - 1) step(0, 8'h00, 0);
        step(1, 8'h1C, 0);
        check("t3_edge_head", 32'({ev_ext, ev_break, ev_code}), 32'h21C);
        drain();
        // Error byte clears the prefix.
        step(1, 8'hE0, 0);
        step(1, 8'hFF, 0);
        step(1, 8'h1A, 0);
        check("t3_err_head", 32'({ev_ext, ev_break, ev_code}), 32'h01A);
        drain();

        // Full FIFO with a simultaneous pop and write.
        step(1, 8'h15, 0);
        step(1, 8'h1D, 0);
        step(1, 8'h24, 0);
        step(1, 8'h2D, 0);
        check("t4_full_count", 32'(ev_count), 4);
        step(1, 8'h2C, 1);
        check("t4_pop_write_count", 32'(ev_count), 4);
        check("t4_no_overflow", 32'(overflow), 0);
        drain();

        // Overflow.
        step(1, 8'h15, 0);
        step(1, 8'h1D, 0);
        step(1, 8'h24, 0);
        step(1, 8'h2D, 0);
        step(1, 8'h2C, 0);
        check("t5_count", 32'(ev_count), 4);
        check("t5_overflow", 32'(overflow), 1);
        drain();
        check("t5_overflow_sticky", 32'(overflow), 1);

        // Reset mid-sequence, asynchronous.
        step(1, 8'h33, 0);
        step(1, 8'hE0, 0);
        mon_en = 0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ev_valid), 0);
        check("mid_rst_count", 32'(ev_count), 0);
        check("mid_rst_overflow", 32'(overflow), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1;
        step(1, 8'h1C, 0);
        check("mid_rst_prefix_gone", 32'({ev_ext, ev_break, ev_code}), 32'h01C);
        drain();

        // Typematic sequence.
        p0 = n_pops;
        step(1, 8'h1C, 1);
        step(1, 8'h1C, 1);
        step(1, 8'h1C, 1);
        step(1, 8'hF0, 1);
        step(1, 8'h1C, 1);
        step(1, 8'h1C, 1);
        drain();
        step(0, 8'h00, 1);
        check("typematic_events", 32'(n_pops - p0), 32'(EXP_TM));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit rdy;
            r   = int'($urandom_range(0, 99));
            rdy = ((i / 50) % 4 == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (r < 4) begin
                int g;
                g = T - 2 + int'($urandom_range(0, 4));
                repeat (g) step(0, 8'h00, rdy);
            end else if (r < 64) begin
                logic [7:0] b;
                if (r < 56) b = tbl[$urandom_range(0, 11)];
                else b = 8'($urandom);
                step(1, b, rdy);
            end else begin
                step(0, 8'h00, rdy);
            end
        end
        drain();
        check("final_sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_event.md
# ps2_key_event

Converts the raw PS/2 scan-byte stream from the receiver stage (`scan_done_tick`/`scan_out`) into complete key events. Each event carries a code byte plus make/break and extended flags. The block resolves the 0xE0/0xF0 prefix sequences, discards keyboard error bytes and stale partial sequences, and buffers events in a small first-word-fall-through FIFO with a valid/ready handshake. It sits between the PS/2 byte receiver and the key-counting/display logic.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of two, ≥2.
- `TIMEOUT_CYC`, default 50000: idle cycles after which a pending prefix is abandoned (1 ms at 50 MHz).
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `scan_done_tick`  in  1  one-cycle strobe; `scan_out` is valid this cycle.
- `scan_out`  in  8  received scan byte.
- `ev_valid`  out  1  FIFO non-empty; head event presented.
- `ev_ready`  in  1  consumer accepts head event when `ev_valid` is also high.
- `ev_code`  out  8  head event key code.
- `ev_break`  out  1  head event is a release (preceded by F0).
- `ev_ext`  out  1  head event is extended (preceded by E0).
- `ev_count`  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky; an event was lost because the FIFO was full.

## Operation
- Prefix FSM states and transitions on each `scan_done_tick`:
  - `IDLE`: E0→`EXT`; F0→`BRK`.
  - `EXT`: F0→`EXT_BRK`; E0 stays in `EXT`.
  - `BRK`: E0→`EXT_BRK`; F0 stays in `BRK`.
  - `EXT_BRK`: E0 and F0 stay in `EXT_BRK`.
  - Any state, byte 0x00, 0xFF or 0xE1: byte dropped, →`IDLE`, no event.
  - Any state, any other byte: emit event {ext, brk, code} with ext = state ∈ {`EXT`, `EXT_BRK`} and brk = state ∈ {`BRK`, `EXT_BRK`}, then →`IDLE`.
- Timeout counter:
  - Cleared on every `scan_done_tick` and while in `IDLE`.
  - Counts while in a prefix state; reaching `TIMEOUT_CYC` forces →`IDLE` with no event.
- FIFO:
  - 10-bit entries {ext, brk, code}; outputs show the head entry (first-word fall-through).
  - Pop when `ev_valid && ev_ready`.
  - An emitted event is written if not full.
  - If full and no pop occurs in the same cycle, the event is dropped and `overflow` is set (sticky until reset).
  - Full with a pop in the same cycle: the write succeeds and occupancy stays at `FIFO_DEPTH`.
  - Empty with a write: no pop can occur that cycle (`ev_valid` is low).
- Pointers wrap modulo `FIFO_DEPTH`; `ev_count` = write count minus read count, in range 0..`FIFO_DEPTH`.
- Head outputs are don't-care while `ev_valid` = 0; the bench must not check them then.

## Timing
- Reset state: FSM `IDLE`, FIFO empty, timeout counter 0, `ev_valid` = 0, `ev_count` = 0, `overflow` = 0, `ev_code`/`ev_break`/`ev_ext` = 0, typematic state cleared.
- Reset mid-sequence discards the pending prefix and all buffered events immediately (asynchronous assertion).
- Latency: final byte strobed in cycle N → `ev_valid` high and head fields valid in cycle N+1.
- Pop in cycle M → next entry, or `ev_valid` = 0, visible in cycle M+1. `ev_count` updates on the same edge.
- Accepts one byte per cycle; back-to-back strobes are legal.
- Timeout fires exactly `TIMEOUT_CYC` cycles after the last strobe; a strobe in the firing cycle takes precedence over the timeout.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN` defined:
  - The block holds the last emitted make event {ext, code} plus a held flag.
  - A make event matching a held key is silently dropped; it neither enters the FIFO nor sets `overflow`.
  - A matching break event clears the held flag.
  - A make event for a different key replaces the held key.
  - The break event itself is always emitted.
- Not defined: every decoded event, including typematic repeats, enters the FIFO.

## Test plan
- Byte 0x1C, `ev_ready` = 1 → one cycle later `ev_valid` = 1, `ev_code` = 0x1C, `ev_break` = 0, `ev_ext` = 0; `ev_count` returns to 0 after the pop.
- Bytes F0, 1C then E0, F0, 75 with `ev_ready` = 0 → `ev_count` = 2; the head is {0,1,0x1C}, and after one pop the head is {ext=1, brk=1, 0x75}.
- Byte E0, then no strobes for `TIMEOUT_CYC` cycles, then 0x1C → event {ext=0, brk=0, 0x1C}. Byte E0 followed by 0xFF → no event, FSM in `IDLE`.
- `FIFO_DEPTH` = 4, `ev_ready` = 0, makes 0x15, 0x1D, 0x24, 0x2D, 0x2C → `ev_count` = 4 and `overflow` = 1; draining yields 15, 1D, 24, 2D in order, and `overflow` stays 1.
- FIFO full, with a byte strobe and `ev_ready` = 1 in the same cycle → `ev_count` stays 4, `overflow` stays 0, and the new event appears last.
- Sequence 1C 1C 1C F0 1C 1C: with `PS2_TYPEMATIC_FILTER_EN` → 3 events (make, break, make); without it → 5 events (make×3, break, make).
